// File: rtl/dbg_mailbox_if.sv
// Bus bundle between the CPU/host side of the debug mailbox and its controller.
// Latency: none (wires only).
// Backpressure: none here; flow state travels in CPU_STATUS and HOST_OUT.
// Ports (slave = mailbox view):
//   CPU_WE/CPU_WD   in   push a word into the TX FIFO
//   CPU_RE          in   pop the RX slot
//   CPU_RD          out  RX slot data
//   CPU_STATUS      out  {tx_full, tx_empty, rx_valid, rx_overrun}
//   HOST_CAPTURE    in   one-cycle pulse, host captured the chain
//   HOST_UPDATE     in   one-cycle pulse, host updated the chain
//   HOST_IN         in   {ack, wvalid, data}
//   HOST_OUT        out  {tx_valid, rx_full, head_data}
//   TX_DROP         out  one-cycle pulse, push discarded because FIFO was full
//   IRQ             out  RX slot holds a word
interface dbg_mailbox_if #(
    parameter int W = 32
);
    logic           CPU_WE;
    logic [W-1:0]   CPU_WD;
    logic           CPU_RE;
    logic [W-1:0]   CPU_RD;
    logic [3:0]     CPU_STATUS;
    logic           HOST_CAPTURE;
    logic           HOST_UPDATE;
    logic [W+1:0]   HOST_IN;
    logic [W+1:0]   HOST_OUT;
    logic           TX_DROP;
    logic           IRQ;

    modport slave (
        input  CPU_WE, CPU_WD, CPU_RE, HOST_CAPTURE, HOST_UPDATE, HOST_IN,
        output CPU_RD, CPU_STATUS, HOST_OUT, TX_DROP, IRQ
    );

    modport master (
        output CPU_WE, CPU_WD, CPU_RE, HOST_CAPTURE, HOST_UPDATE, HOST_IN,
        input  CPU_RD, CPU_STATUS, HOST_OUT, TX_DROP, IRQ
    );
endinterface

// File: rtl/dbg_mailbox.sv
// Debug data-IO chain mailbox: CPU->host TX FIFO plus host->CPU single-entry RX slot.
// Latency: push visible on HOST_OUT one cycle later; host writes land in the RX slot in one cycle.
// Backpressure: TX pushes while full are dropped (TX_DROP pulse); RX writes while full set rx_overrun.
// Ports:
//   CLK    in  CPU clock
//   RESET  in  synchronous active-high reset
//   bus    slave modport of dbg_mailbox_if (CPU and host-chain signals)
// DEPTH must be a power of two, >= 2, so the pointers wrap naturally.
module dbg_mailbox #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic          CLK,
    input  logic          RESET,
    dbg_mailbox_if.slave  bus
);

    localparam int PW = $clog2(DEPTH);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;

    logic [W-1:0]   r_mem [DEPTH];
    logic [PW-1:0]  r_wr_ptr;
    logic [PW-1:0]  r_rd_ptr;
    logic [PW:0]    r_count;
    logic           r_rx_valid;
    logic           r_rx_overrun;
    logic [W-1:0]   r_rx_data;
    logic [W+1:0]   r_host_out;
    logic           r_presented;
    logic           r_tx_drop;

    logic           w_tx_full;
    logic           w_tx_empty;
    logic           w_ack;
    logic           w_wvalid;
    logic           w_push;
    logic           w_pop;
    logic           w_load_out;
    logic           w_present_ld;
    logic           w_rx_accept;
    logic           w_rx_reject;
    logic           w_rx_valid_nxt;
    logic           w_rx_overrun_nxt;
    logic [PW-1:0]  w_rd_ptr_nxt;
    logic [PW:0]    w_count_nxt;
    logic [W-1:0]   w_head_nxt;

    assign w_tx_full  = (r_count == (PW+1)'(DEPTH));
    assign w_tx_empty = (r_count == '0);
    assign w_ack      = bus.HOST_IN[W+1];
    assign w_wvalid   = bus.HOST_IN[W];

    // Full is judged on the pre-cycle count, so a push in the same cycle as
    // the pop that would free a slot is still dropped.
    assign w_push = bus.CPU_WE && !w_tx_full;

    // A host write is taken if the slot is free or the CPU empties it this cycle.
    assign w_rx_accept = bus.HOST_UPDATE && w_wvalid && (!r_rx_valid || bus.CPU_RE);
    assign w_rx_reject = bus.HOST_UPDATE && w_wvalid && !w_rx_accept;

    // Chain arbitration. The ack bit only means something for a value the host
    // actually captured, so pops happen solely on an update closing a LOCKED window.
    always_comb begin
        w_state_nxt  = r_state;
        w_pop        = 1'b0;
        w_load_out   = 1'b0;
        w_present_ld = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_load_out = 1'b1;
                if (bus.HOST_CAPTURE) begin
                    w_state_nxt  = ST_LOCKED;
                    w_present_ld = 1'b1;
                end
            end
            ST_LOCKED: begin
                if (bus.HOST_UPDATE) begin
                    // Empty guard keeps the count sane even if a stale
                    // presented flag survives a capture+update back-to-back.
                    w_pop        = w_ack && r_presented && !w_tx_empty;
                    w_state_nxt  = bus.HOST_CAPTURE ? ST_LOCKED : ST_IDLE;
                    w_present_ld = bus.HOST_CAPTURE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_rd_ptr_nxt = w_pop ? (r_rd_ptr + PW'(1)) : r_rd_ptr;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + (PW+1)'(1);
            2'b01:   w_count_nxt = r_count - (PW+1)'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    assign w_rx_valid_nxt   = w_rx_accept || (r_rx_valid && !bus.CPU_RE);
    assign w_rx_overrun_nxt = w_rx_reject || (r_rx_overrun && !bus.CPU_RE);

    // HOST_OUT is loaded from the post-edge FIFO/RX state so it always mirrors
    // the registers. When the word being pushed becomes the head it is bypassed
    // from CPU_WD since the memory write lands on the same edge. An empty FIFO
    // presents zero data rather than a stale entry.
    always_comb begin
        w_head_nxt = r_mem[w_rd_ptr_nxt];
        if (w_count_nxt == '0) begin
            w_head_nxt = '0;
        end else if (w_push && (w_rd_ptr_nxt == r_wr_ptr)) begin
            w_head_nxt = bus.CPU_WD;
        end
    end

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.CPU_WD;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state      <= ST_IDLE;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_rx_valid   <= 1'b0;
            r_rx_overrun <= 1'b0;
            r_rx_data    <= '0;
            r_host_out   <= '0;
            r_presented  <= 1'b0;
            r_tx_drop    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_rd_ptr     <= w_rd_ptr_nxt;
            r_count      <= w_count_nxt;
            r_rx_valid   <= w_rx_valid_nxt;
            r_rx_overrun <= w_rx_overrun_nxt;
            r_tx_drop    <= bus.CPU_WE && w_tx_full;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_rx_accept) begin
                r_rx_data <= bus.HOST_IN[W-1:0];
            end
            // Remember whether the captured value carried a word, using the
            // HOST_OUT the host saw in the capture cycle.
            if (w_present_ld) begin
                r_presented <= r_host_out[W+1];
            end
            if (w_load_out) begin
                r_host_out <= {(w_count_nxt != '0), w_rx_valid_nxt, w_head_nxt};
            end
        end
    end

    assign bus.CPU_RD     = r_rx_data;
    assign bus.CPU_STATUS = {w_tx_full, w_tx_empty, r_rx_valid, r_rx_overrun};
    assign bus.HOST_OUT   = r_host_out;
    assign bus.TX_DROP    = r_tx_drop;
    assign bus.IRQ        = r_rx_valid;

endmodule

// File: doc/dbg_mailbox.md
Name: dbg_mailbox

Overview:
- CPU-clock-domain mailbox controller for the 32-bit debug data-IO scan chain; arbitrates that single chain between CPU→host and host→CPU traffic.
- CPU pushes words into a TX FIFO; the host drains them through the chain. The host writes words into a single-entry RX slot, which the CPU pops.
- Capture/update events reach this block already synchronized and edge-detected to CLK. The chain's capture value is held stable while a host access is in flight.

Parameters:
- DEPTH, 4, TX FIFO depth in words; power of 2, ≥2.
- W, 32, data word width.

Ports:
- CLK  in  1  CPU clock.
- RESET  in  1  synchronous, active-high reset.
- CPU_WE  in  1  push CPU_WD into TX FIFO.
- CPU_WD  in  W  CPU transmit word.
- CPU_RE  in  1  pop RX slot.
- CPU_RD  out  W  RX slot contents.
- CPU_STATUS  out  4  {tx_full, tx_empty, rx_valid, rx_overrun}.
- HOST_CAPTURE  in  1  one-cycle pulse: host captured chain.
- HOST_UPDATE  in  1  one-cycle pulse: host updated chain.
- HOST_IN  in  W+2  chain update value {ack, wvalid, data}.
- HOST_OUT  out  W+2  chain capture value {tx_valid, rx_full, head_data}.
- TX_DROP  out  1  one-cycle pulse: CPU_WE while FIFO full, word discarded.
- IRQ  out  1  = rx_valid.

Behaviour:
- Reset values: FIFO empty, rd/wr ptr 0, count 0, rx_valid 0, rx_overrun 0, RX data 0, HOST_OUT 0, TX_DROP 0, state IDLE. Pulses arriving in the reset cycle are ignored.
- TX FIFO:
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - Count is log2(DEPTH)+1 bits.
  - tx_full = (count==DEPTH); tx_empty = (count==0).
  - CPU_WE while full: no write; TX_DROP=1 for the next cycle.
  - Pop only via host ack (see below).
  - Simultaneous push and pop with count==DEPTH: pop occurs, push is dropped (full evaluated on pre-cycle state).
- HOST_OUT is registered. State machine:
  - IDLE:
    - HOST_OUT <= {~tx_empty, rx_valid, head} every cycle.
    - A CPU push into an empty FIFO appears on HOST_OUT one cycle after the push cycle.
    - HOST_CAPTURE → LOCKED; presented <= HOST_OUT[W+1] (value in that cycle).
    - HOST_UPDATE while in IDLE: process wvalid only; ack is ignored (no capture ⇒ nothing presented).
  - LOCKED:
    - HOST_OUT frozen. CPU pushes and CPU_RE still proceed.
    - HOST_CAPTURE again: stay LOCKED, presented unchanged.
    - HOST_UPDATE → IDLE (next cycle), with:
      - if ack && presented: pop FIFO head (rd_ptr+1, count-1).
      - if wvalid: if (!rx_valid || CPU_RE same cycle), RX data <= HOST_IN data and rx_valid <= 1; else rx_overrun <= 1 and RX data is kept.
- HOST_CAPTURE and HOST_UPDATE in the same cycle: UPDATE processed first under current state, then the next state is LOCKED.
- RX slot:
  - CPU_RD = RX data register.
  - CPU_RE clears rx_valid and rx_overrun, except when replaced by an accepted host write in the same cycle (then rx_valid stays 1 with new data).
  - CPU_RE with rx_valid=0: no effect besides clearing overrun.
- IRQ = rx_valid, combinational from the register.
- Reset mid-LOCKED: returns to IDLE. Any pending ack is lost; the FIFO is emptied.

Test Plan:
- After reset, CPU_WE with WD=0xDEADBEEF → next cycle HOST_OUT = {1,0,0xDEADBEEF}; CPU_STATUS = {0,0,0,0}.
- Push 0x11,0x22,0x33,0x44 (DEPTH=4), then push 0x55 → tx_full=1, TX_DROP pulses once. Four capture/update cycles with ack=1 → HOST_OUT heads 0x11,0x22,0x33,0x44 in order, then tx_empty=1 and HOST_OUT[W+1]=0.
- Capture, CPU pushes 0x77 while LOCKED → HOST_OUT stays frozen at pre-capture value until update. Update with ack=1 pops exactly one word.
- Update (no capture) with {ack=1, wvalid=1, 0xCAFE0001} → RX=0xCAFE0001, IRQ=1, FIFO untouched. Second write 0x2 before CPU_RE → rx_overrun=1, CPU_RD still 0xCAFE0001. CPU_RE → status rx bits 0.
- rx_valid=1, host write 0x5 in same cycle as CPU_RE → rx_valid=1, CPU_RD=0x5, overrun=0.
- Capture, FIFO holding 2 words, RESET asserted before update → FIFO empty, state IDLE. Subsequent update with ack=1 → no pop, count 0.
